// File: rtl/ptr_list_queue.sv
// Linked-list FIFO of unique pointer values: pushes append at the tail, pops
// take the head; a pointer already in the list is dropped and flagged.
module ptr_list_queue #(
    parameter int N     = 256,
    parameter int W_PTR = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_PTR-1:0] in_ptr,
    input  logic             in_ptr_vld,
    output logic [W_PTR-1:0] out_ptr,
    output logic             out_ptr_vld,
    input  logic             out_ptr_rdy,
    output logic [W_PTR:0]   count,
    output logic             dup_drop
);

    logic [W_PTR-1:0] head_q, head_d;
    logic [W_PTR-1:0] tail_q, tail_d;
    logic [W_PTR:0]   count_q, count_d;
    logic [N-1:0]     member_q, member_d;
    logic             vld_q;
    logic             dup_q;
    logic [W_PTR-1:0] nxt_q [N];

    logic push_s;
    logic dup_s;
    logic pop_s;
    logic empty_after_s;

    assign push_s = in_ptr_vld & ~member_q[in_ptr];
    assign dup_s  = in_ptr_vld &  member_q[in_ptr];
    assign pop_s  = vld_q & out_ptr_rdy;
    // The new pointer becomes head when nothing older survives this edge.
    assign empty_after_s = (count_q == {(W_PTR+1){1'b0}}) ||
                           (pop_s && (count_q == (W_PTR+1)'(1)));

    // Next-state for head, tail, count and the membership bitmap.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        member_d = member_q;
        count_d  = count_q + (W_PTR+1)'(push_s) - (W_PTR+1)'(pop_s);

        if (pop_s) begin
            member_d[head_q] = 1'b0;
            if (count_q != (W_PTR+1)'(1)) begin
                head_d = nxt_q[head_q];
            end else begin
                head_d = head_q;
            end
        end else begin
            member_d = member_q;
        end

        if (push_s) begin
            member_d[in_ptr] = 1'b1;
            tail_d           = in_ptr;
            if (empty_after_s) begin
                head_d = in_ptr;
            end else begin
                head_d = head_d;
            end
        end else begin
            tail_d = tail_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= {W_PTR{1'b0}};
            tail_q   <= {W_PTR{1'b0}};
            count_q  <= {(W_PTR+1){1'b0}};
            member_q <= {N{1'b0}};
            vld_q    <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            member_q <= member_d;
            vld_q    <= (count_d != {(W_PTR+1){1'b0}});
            dup_q    <= dup_s;
        end
    end

    // Link storage needs no reset: entries are written before they are read.
    always_ff @(posedge clk) begin
        if (!rst && push_s && !empty_after_s) begin
            nxt_q[tail_q] <= in_ptr;
        end
    end

    assign out_ptr     = head_q;
    assign out_ptr_vld = vld_q;
    assign count       = count_q;
    assign dup_drop    = dup_q;

endmodule

// File: tb/tb_ptr_list_queue.sv
// Directed self-checking bench for ptr_list_queue.
module tb_ptr_list_queue;

    logic       clk;
    logic       rst;
    logic [7:0] in_ptr;
    logic       in_ptr_vld;
    logic [7:0] out_ptr;
    logic       out_ptr_vld;
    logic       out_ptr_rdy;
    logic [8:0] count;
    logic       dup_drop;

    int checks;
    int errors;
    logic [7:0] order [256];

    ptr_list_queue dut (
        .clk         (clk),
        .rst         (rst),
        .in_ptr      (in_ptr),
        .in_ptr_vld  (in_ptr_vld),
        .out_ptr     (out_ptr),
        .out_ptr_vld (out_ptr_vld),
        .out_ptr_rdy (out_ptr_rdy),
        .count       (count),
        .dup_drop    (dup_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, then settle just past the rising edge.
    task automatic cyc(input logic v, input logic [7:0] p, input logic r);
        in_ptr_vld  = v;
        in_ptr      = p;
        out_ptr_rdy = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_ptr_vld = 1'b1;
        in_ptr = 8'd0;
        out_ptr_rdy = 1'b1;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            cyc(1'($urandom), 8'($urandom), 1'($urandom));
            chk("rst_vld", out_ptr_vld, 0);
            chk("rst_cnt", count, 0);
            chk("rst_dup", dup_drop, 0);
            chk("rst_ptr", out_ptr, 0);
        end
        rst = 1'b0;
        cyc(1'b0, 8'd0, 1'b0);
        chk("post_rst_vld", out_ptr_vld, 0);
        chk("post_rst_cnt", count, 0);

        // Push-only ordering.
        cyc(1'b1, 8'd5, 1'b0);
        chk("p5_cnt", count, 1);
        chk("p5_vld", out_ptr_vld, 1);
        chk("p5_out", out_ptr, 5);
        cyc(1'b1, 8'd17, 1'b0);
        chk("p17_cnt", count, 2);
        chk("p17_out", out_ptr, 5);
        cyc(1'b1, 8'd3, 1'b0);
        chk("p3_cnt", count, 3);
        cyc(1'b0, 8'd0, 1'b1);
        chk("pop1_out", out_ptr, 17);
        chk("pop1_cnt", count, 2);
        cyc(1'b0, 8'd0, 1'b1);
        chk("pop2_out", out_ptr, 3);
        chk("pop2_cnt", count, 1);
        cyc(1'b0, 8'd0, 1'b1);
        chk("pop3_vld", out_ptr_vld, 0);
        chk("pop3_cnt", count, 0);
        cyc(1'b0, 8'd0, 1'b1);
        chk("empty_rdy_cnt", count, 0);

        // Duplicate detection and re-push after pop.
        cyc(1'b1, 8'd9, 1'b0);
        chk("p9_cnt", count, 1);
        chk("p9_dup", dup_drop, 0);
        cyc(1'b1, 8'd9, 1'b0);
        chk("dup9_dup", dup_drop, 1);
        chk("dup9_cnt", count, 1);
        cyc(1'b0, 8'd0, 1'b0);
        chk("dup9_pulse_end", dup_drop, 0);
        cyc(1'b0, 8'd0, 1'b1);
        chk("pop9_cnt", count, 0);
        cyc(1'b1, 8'd9, 1'b0);
        chk("repush9_cnt", count, 1);
        chk("repush9_dup", dup_drop, 0);
        chk("repush9_out", out_ptr, 9);

        // Single element: replace with a different value, then self-replace.
        cyc(1'b1, 8'd7, 1'b1);
        chk("swap7_out", out_ptr, 7);
        chk("swap7_cnt", count, 1);
        cyc(1'b1, 8'd42, 1'b1);
        chk("swap42_out", out_ptr, 42);
        chk("swap42_cnt", count, 1);
        chk("swap42_vld", out_ptr_vld, 1);
        cyc(1'b1, 8'd42, 1'b1);
        chk("self42_dup", dup_drop, 1);
        chk("self42_cnt", count, 0);
        chk("self42_vld", out_ptr_vld, 0);

        // Simultaneous push/pop on a longer list keeps order.
        cyc(1'b1, 8'd10, 1'b0);
        cyc(1'b1, 8'd11, 1'b0);
        cyc(1'b1, 8'd12, 1'b1);
        chk("pp_out", out_ptr, 11);
        chk("pp_cnt", count, 2);
        cyc(1'b0, 8'd0, 1'b1);
        chk("pp_out2", out_ptr, 12);
        cyc(1'b0, 8'd0, 1'b1);
        chk("pp_empty", out_ptr_vld, 0);

        // Fill all 256 values in a permuted order.
        for (int i = 0; i < 256; i++) begin
            order[i] = 8'((i * 37 + 11) % 256);
            cyc(1'b1, order[i], 1'b0);
        end
        chk("full_cnt", count, 256);
        chk("full_dup", dup_drop, 0);
        cyc(1'b1, 8'd100, 1'b0);
        chk("full_dup100", dup_drop, 1);
        chk("full_cnt_hold", count, 256);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("drain_%0d", i), out_ptr, order[i]);
            cyc(1'b0, 8'd0, 1'b1);
        end
        chk("drain_vld", out_ptr_vld, 0);
        chk("drain_cnt", count, 0);

        // Reset mid-stream.
        cyc(1'b1, 8'd1, 1'b0);
        cyc(1'b1, 8'd2, 1'b0);
        cyc(1'b1, 8'd3, 1'b0);
        chk("mid_cnt", count, 3);
        rst = 1'b1;
        cyc(1'b1, 8'd4, 1'b1);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_vld", out_ptr_vld, 0);
        rst = 1'b0;
        cyc(1'b1, 8'd2, 1'b0);
        chk("mid_p2_dup", dup_drop, 0);
        chk("mid_p2_cnt", count, 1);
        chk("mid_p2_out", out_ptr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ptr_list_queue.md
# ptr_list_queue

Linked-list FIFO that consumes the pointer stream produced by the request generator (`in_ptr`/`in_ptr_vld`, one pointer per valid cycle, no backpressure) and orders the pointers into a singly linked list. The list is stored in an internal next-pointer array indexed by pointer value. The block hands pointers out in arrival order through a valid/ready pop port. Each pointer value is held at most once; a repeated value is dropped and flagged.

## Interface
- `n`, 256: number of list nodes; pointer values are 0..n-1.
- `w_ptr`, `$clog2(n)`: pointer width. `ptr_t` is `logic [w_ptr-1:0]`.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_ptr`  in  w_ptr  pointer to append; sampled when `in_ptr_vld` is 1.
- `in_ptr_vld`  in  1  push request; always accepted, with no ready signal.
- `out_ptr`  out  w_ptr  current list head, registered.
- `out_ptr_vld`  out  1  list is non-empty; `out_ptr` is meaningful.
- `out_ptr_rdy`  in  1  consumer takes the head when `out_ptr_vld & out_ptr_rdy`.
- `count`  out  w_ptr+1  number of pointers in the list, 0..n.
- `dup_drop`  out  1  one-cycle pulse: the push in the previous cycle was dropped as a duplicate.

## Operation
- **State:**
  - `head` and `tail` (ptr_t).
  - `count`.
  - `nxt[n]` (ptr_t array, no reset needed).
  - `member[n]` bitmap, cleared on reset.
- **Push** (`in_ptr_vld`, `member[in_ptr]==0`, membership taken from pre-edge state):
  - Set `member[in_ptr]`.
  - If the list is effectively empty after this cycle's pop, `head<=in_ptr`.
  - Otherwise `nxt[tail]<=in_ptr`.
  - `tail<=in_ptr`.
- **Duplicate push** (`member[in_ptr]==1`):
  - No state change.
  - `dup_drop<=1` for one cycle.
- **Pop** (`out_ptr_vld & out_ptr_rdy`):
  - Clear `member[head]`.
  - If `count==1`: the list becomes empty, unless a push happens in the same cycle, in which case `head<=in_ptr`.
  - Otherwise `head<=nxt[head]`.
- **Simultaneous push and pop:**
  - Both take effect.
  - `count` is unchanged.
  - Tail append uses the old `tail`. If the old list had one element and it is popped, the pushed pointer becomes both `head` and `tail`.
- **Push of the value being popped in the same cycle:** dropped as a duplicate, because membership is checked pre-edge.
- **`count` arithmetic:** `count + push_acc - pop_acc`, width w_ptr+1, never exceeds n.
  - Because of membership, a full list (count==n) cannot take a new pointer: every push is a duplicate.
- **`out_ptr_vld`** is defined as `count != 0`.
- **`out_ptr_rdy` while empty** has no effect.
- **Reset mid-operation:**
  - The list empties and `member` clears.
  - `nxt` contents become don't-care.
  - Inputs in the reset cycle are ignored.

## Timing
- **Reset values:**
  - `out_ptr=0`, `out_ptr_vld=0`, `count=0`, `dup_drop=0`.
  - `head=0`, `tail=0`, all `member` bits 0.
- **Push latency:** a pointer pushed at edge t into an empty list appears on `out_ptr` with `out_ptr_vld=1` after edge t, i.e. 1 cycle.
- **Pop:** the next head is presented on the cycle after the pop edge, so back-to-back pops sustain 1 pointer/cycle.
- **Throughput:** 1 push and 1 pop per cycle, sustained indefinitely.
- **Outputs:** all are registered, with no combinational path from inputs to outputs.
- **`dup_drop`:** asserted in the cycle after the offending push.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random inputs -> `out_ptr_vld=0`, `count=0`, `dup_drop=0` throughout and after release.
- **Push-only ordering:** push 5, 17, 3 on consecutive cycles with `out_ptr_rdy=0` -> `count` goes 1,2,3. Then hold `rdy=1` -> `out_ptr` is 5, 17, 3 on consecutive cycles, then `out_ptr_vld=0`, `count=0`.
- **Duplicate:**
  - Push 9, then 9 again -> second push sets `dup_drop=1` for one cycle and `count` stays 1.
  - Pop 9, then push 9 -> accepted, `count=1`.
- **Simultaneous push/pop on a single element:** list = {7}; on the same edge pop and push 42 -> `out_ptr=42`, `count=1`. Pushing 7 while popping 7 instead -> `dup_drop=1`, list empty.
- **Full list:** push all 0..255 -> `count=256`. Push 100 -> `dup_drop=1`. Drain with `rdy=1` -> the 256 values come out in push order, then `out_ptr_vld=0`.
- **Reset mid-stream:** list holds {1,2,3}; assert `rst` 1 cycle -> empty. Then push 2 -> accepted (no dup) and `out_ptr=2` next cycle.
